// File: rtl/program_mem_arbiter_pkg.sv
// Shared types and helpers for program_mem_arbiter.
// Optional feature macro: PROGRAM_FETCH_BYPASS_EN (see program_mem_arbiter.sv).
package program_mem_arb_pkg;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'b00,
        CH_WAITING  = 2'b01,
        CH_RELAYING = 2'b10
    } chan_state_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/program_mem_arbiter_if.sv
// Fetcher-side and program-memory-side signals of program_mem_arbiter.
// master = arbiter view, slave = fetchers plus memory controller.
interface program_mem_arbiter_if #(
    parameter int unsigned NUM_CONSUMERS         = 4,
    parameter int unsigned NUM_CHANNELS          = 1,
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
);
    logic [NUM_CONSUMERS-1:0]                            consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][PROGRAM_MEM_ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                            consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][PROGRAM_MEM_DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CHANNELS-1:0]                             mem_read_valid;
    logic [NUM_CHANNELS-1:0][PROGRAM_MEM_ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                             mem_read_ready;
    logic [NUM_CHANNELS-1:0][PROGRAM_MEM_DATA_BITS-1:0]  mem_read_data;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data
    );
endinterface

// File: rtl/program_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting, non-excluded
// consumer at or after the start pointer, in modulo order.
import program_mem_arb_pkg::*;

module rr_pick #(
    parameter int unsigned NUM_CONSUMERS = 4,
    localparam int unsigned OW = clog2_min1(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] req,
    input  logic [NUM_CONSUMERS-1:0] excl,
    input  logic [OW-1:0]            start,
    output logic                     grant_valid,
    output logic [OW-1:0]            grant_idx
);
    int unsigned cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            cand = 32'(start) + i;
            if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
            if (!grant_valid && req[cand] && !excl[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = OW'(cand);
            end
        end
    end
endmodule

// File: rtl/program_mem_arbiter.sv
// Round-robin sharing of program-memory read channels among instruction fetchers.
// Define PROGRAM_FETCH_BYPASS_EN to serve repeat addresses from a per-channel last-read register.
import program_mem_arb_pkg::*;

module program_mem_arbiter #(
    parameter int unsigned NUM_CONSUMERS         = 4,
    parameter int unsigned NUM_CHANNELS          = 1,
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    program_mem_arbiter_if.master bus
);
    localparam int unsigned NC = NUM_CONSUMERS;
    localparam int unsigned CH = NUM_CHANNELS;
    localparam int unsigned AB = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned DB = PROGRAM_MEM_DATA_BITS;
    localparam int unsigned OW = clog2_min1(NC);

    typedef logic [OW-1:0] idx_t;

    chan_state_t              state_q [CH];
    chan_state_t              state_n [CH];
    idx_t                     owner_q [CH];
    idx_t                     owner_n [CH];
    logic [CH-1:0]            mem_valid_q, mem_valid_n;
    logic [CH-1:0][AB-1:0]    mem_addr_q, mem_addr_n;
    logic [NC-1:0]            ready_q, ready_n;
    logic [NC-1:0][DB-1:0]    data_q, data_n;
    idx_t                     rr_ptr_q, rr_ptr_n;
    logic [NC-1:0]            owned;
    logic [CH-1:0]            gnt_take;
    idx_t                     gnt_idx [CH];
`ifdef PROGRAM_FETCH_BYPASS_EN
    logic [CH-1:0]            last_valid_q, last_valid_n;
    logic [CH-1:0][AB-1:0]    last_addr_q, last_addr_n;
    logic [CH-1:0][DB-1:0]    last_data_q, last_data_n;
`endif

    assign bus.consumer_read_ready = ready_q;
    assign bus.consumer_read_data  = data_q;
    assign bus.mem_read_valid      = mem_valid_q;
    assign bus.mem_read_address    = mem_addr_q;

    always_comb begin
        owned = '0;
        for (int unsigned c = 0; c < CH; c++)
            if (state_q[c] != CH_IDLE) owned[owner_q[c]] = 1'b1;
    end

    // Each channel's picker excludes everything already owned plus what lower channels take this cycle.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [NC-1:0] excl_in;
        logic [NC-1:0] excl_out;
        logic          pick_valid;

        if (c == 0) begin : g_first
            assign excl_in = owned;
        end else begin : g_next
            assign excl_in = g_ch[c-1].excl_out;
        end

        rr_pick #(.NUM_CONSUMERS(NC)) u_pick (
            .req         (bus.consumer_read_valid),
            .excl        (excl_in),
            .start       (rr_ptr_q),
            .grant_valid (pick_valid),
            .grant_idx   (gnt_idx[c])
        );

        assign gnt_take[c] = pick_valid && (state_q[c] == CH_IDLE);
        assign excl_out    = gnt_take[c] ? (excl_in | (NC'(1) << gnt_idx[c])) : excl_in;
    end

    always_comb begin
        state_n     = state_q;
        owner_n     = owner_q;
        mem_valid_n = mem_valid_q;
        mem_addr_n  = mem_addr_q;
        ready_n     = ready_q;
        data_n      = data_q;
        rr_ptr_n    = rr_ptr_q;
`ifdef PROGRAM_FETCH_BYPASS_EN
        last_valid_n = last_valid_q;
        last_addr_n  = last_addr_q;
        last_data_n  = last_data_q;
`endif
        for (int unsigned c = 0; c < CH; c++) begin
            case (state_q[c])
                CH_IDLE: begin
                    if (gnt_take[c]) begin
                        owner_n[c] = gnt_idx[c];
                        rr_ptr_n   = (gnt_idx[c] == idx_t'(NC - 1)) ? '0 : idx_t'(gnt_idx[c] + 1'b1);
`ifdef PROGRAM_FETCH_BYPASS_EN
                        if (last_valid_q[c] &&
                            last_addr_q[c] == bus.consumer_read_address[gnt_idx[c]]) begin
                            state_n[c]             = CH_RELAYING;
                            ready_n[gnt_idx[c]]    = 1'b1;
                            data_n[gnt_idx[c]]     = last_data_q[c];
                        end else
`endif
                        begin
                            state_n[c]     = CH_WAITING;
                            mem_valid_n[c] = 1'b1;
                            mem_addr_n[c]  = bus.consumer_read_address[gnt_idx[c]];
                        end
                    end
                end
                CH_WAITING: begin
                    if (bus.mem_read_ready[c]) begin
                        state_n[c]          = CH_RELAYING;
                        mem_valid_n[c]      = 1'b0;
                        ready_n[owner_q[c]] = 1'b1;
                        data_n[owner_q[c]]  = bus.mem_read_data[c];
`ifdef PROGRAM_FETCH_BYPASS_EN
                        last_valid_n[c] = 1'b1;
                        last_addr_n[c]  = mem_addr_q[c];
                        last_data_n[c]  = bus.mem_read_data[c];
`endif
                    end
                end
                CH_RELAYING: begin
                    if (!bus.consumer_read_valid[owner_q[c]]) begin
                        state_n[c]          = CH_IDLE;
                        ready_n[owner_q[c]] = 1'b0;
                    end
                end
                default: state_n[c] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= CH_IDLE;
                owner_q[c] <= '0;
            end
            mem_valid_q <= '0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
            rr_ptr_q    <= '0;
`ifdef PROGRAM_FETCH_BYPASS_EN
            last_valid_q <= '0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
`endif
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= state_n[c];
                owner_q[c] <= owner_n[c];
            end
            mem_valid_q <= mem_valid_n;
            mem_addr_q  <= mem_addr_n;
            ready_q     <= ready_n;
            data_q      <= data_n;
            rr_ptr_q    <= rr_ptr_n;
`ifdef PROGRAM_FETCH_BYPASS_EN
            last_valid_q <= last_valid_n;
            last_addr_q  <= last_addr_n;
            last_data_q  <= last_data_n;
`endif
        end
    end
endmodule
